icache_ctrl: RTL and testbench

L1 instruction-cache controller for the 2-way, 256-set, 16-byte-line L1 I-cache. It sits between the fetch stage and the L1 tag/data RAM pair.
- Accepts fetch requests and performs the tag lookup.
- Selects a victim on a miss, fetches the line from L2 and writes it into tag/data RAM.
- Returns the addressed 32-bit instruction and keeps hit/miss counters.

---
 rtl/icache_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_icache_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl.sv
// L1 instruction-cache controller: 2-way, 256-set, 16-byte lines.
// Tag lookup, victim selection, L2 refill and hit/miss counters.
module icache_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_req,
    input  logic [31:0]      if_addr,
    input  logic             if_flush,
    output logic             if_busy,
    output logic             if_valid,
    output logic [31:0]      if_insn,
    output logic [7:0]       index,
    output logic [19:0]      tag_wd,
    output logic             tag0_rw,
    output logic             tag1_rw,
    output logic             data0_rw,
    output logic             data1_rw,
    output logic [127:0]     data_wd,
    input  logic [20:0]      tag0_rd,
    input  logic [20:0]      tag1_rd,
    input  logic             LUR,
    input  logic             complete,
    input  logic [127:0]     data0_rd,
    input  logic [127:0]     data1_rd,
    output logic             l2_req,
    output logic [31:0]      l2_addr,
    input  logic             l2_ack,
    input  logic [127:0]     l2_rdata,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam logic WR = 1'b0;
    localparam logic RD = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_WAIT,
        S_REFILL,
        S_WAIT_CMP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:2]      r_addr;
    logic             r_valid;
    logic [31:0]      r_insn;
    logic             r_l2_req;
    logic [31:0]      r_l2_addr;
    logic             r_victim;
    logic [127:0]     r_line;
    logic             r_flush;
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    logic [19:0]      w_tag;
    logic [7:0]       w_idx;
    logic [1:0]       w_word;
    logic             w_hit0;
    logic             w_hit1;
    logic             w_hit;
    logic [127:0]     w_hline;
    logic [31:0]      w_hword;
    logic             w_victim;
    logic             w_accept;
    logic             w_flush;
    logic             w_unused;

    assign w_tag    = r_addr[31:12];
    assign w_idx    = r_addr[11:4];
    assign w_word   = r_addr[3:2];
    assign w_hit0   = tag0_rd[20] && (tag0_rd[19:0] == w_tag);
    assign w_hit1   = tag1_rd[20] && (tag1_rd[19:0] == w_tag);
    assign w_hit    = w_hit0 || w_hit1;
    assign w_hline  = w_hit0 ? data0_rd : data1_rd;
    assign w_hword  = w_hline[{w_word, 5'b0} +: 32];
    // Fill invalid ways first; only consult LUR when both are valid.
    assign w_victim = !tag0_rd[20] ? 1'b0 :
                      !tag1_rd[20] ? 1'b1 : LUR;
    assign w_accept = (r_state == S_IDLE) && if_req && !if_flush;
    assign w_flush  = r_flush || if_flush;
    assign w_unused = ^if_addr[1:0];

    assign index    = (r_state == S_IDLE) ? if_addr[11:4] : w_idx;
    assign if_busy  = (r_state != S_IDLE);
    assign if_valid = r_valid;
    assign if_insn  = r_insn;
    assign l2_req   = r_l2_req;
    assign l2_addr  = r_l2_addr;
    assign tag_wd   = w_tag;
    assign data_wd  = r_line;
    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        tag0_rw  = RD;
        tag1_rw  = RD;
        data0_rw = RD;
        data1_rw = RD;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (if_flush || w_hit) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_MISS_WAIT;
                end
            end
            S_MISS_WAIT: begin
                if (l2_ack) begin
                    w_next = S_REFILL;
                end
            end
            S_REFILL: begin
                if (r_victim) begin
                    tag1_rw  = WR;
                    data1_rw = WR;
                end else begin
                    tag0_rw  = WR;
                    data0_rw = WR;
                end
                w_next = S_WAIT_CMP;
            end
            S_WAIT_CMP: begin
                if (complete) begin
                    w_next = w_flush ? S_IDLE : S_LOOKUP;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr     <= '0;
            r_valid    <= 1'b0;
            r_insn     <= '0;
            r_l2_req   <= 1'b0;
            r_l2_addr  <= '0;
            r_victim   <= 1'b0;
            r_line     <= '0;
            r_flush    <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_valid <= 1'b0;
            if (w_accept) begin
                r_addr <= if_addr[31:2];
            end
            if (r_state == S_LOOKUP && !if_flush) begin
                if (w_hit) begin
                    r_valid <= 1'b1;
                    r_insn  <= w_hword;
                    if (r_hit_cnt != '1) begin
                        r_hit_cnt <= r_hit_cnt + 1'b1;
                    end
                end else begin
                    r_victim  <= w_victim;
                    r_l2_req  <= 1'b1;
                    r_l2_addr <= {w_tag, w_idx, 4'b0};
                    if (r_miss_cnt != '1) begin
                        r_miss_cnt <= r_miss_cnt + 1'b1;
                    end
                end
            end
            if (r_state == S_MISS_WAIT && l2_ack) begin
                r_line   <= l2_rdata;
                r_l2_req <= 1'b0;
            end
            // A flush past LOOKUP lets the refill finish, then skips the reply.
            if (w_next == S_IDLE) begin
                r_flush <= 1'b0;
            end else if (if_flush && (r_state == S_MISS_WAIT ||
                                      r_state == S_REFILL ||
                                      r_state == S_WAIT_CMP)) begin
                r_flush <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl with tag/data RAM, L2 responder
// and a set-level cache reference model.
module tb_icache_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         if_req;
    logic [31:0]  if_addr;
    logic         if_flush;
    logic         if_busy;
    logic         if_valid;
    logic [31:0]  if_insn;
    logic [7:0]   index;
    logic [19:0]  tag_wd;
    logic         tag0_rw, tag1_rw, data0_rw, data1_rw;
    logic [127:0] data_wd;
    logic [20:0]  tag0_rd, tag1_rd;
    logic         LUR;
    logic         complete;
    logic [127:0] data0_rd, data1_rd;
    logic         l2_req;
    logic [31:0]  l2_addr;
    logic         l2_ack;
    logic [127:0] l2_rdata;
    logic [3:0]   hit_cnt, miss_cnt;

    icache_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_busy(if_busy), .if_valid(if_valid), .if_insn(if_insn),
        .index(index), .tag_wd(tag_wd),
        .tag0_rw(tag0_rw), .tag1_rw(tag1_rw),
        .data0_rw(data0_rw), .data1_rw(data1_rw),
        .data_wd(data_wd), .tag0_rd(tag0_rd), .tag1_rd(tag1_rd),
        .LUR(LUR), .complete(complete),
        .data0_rd(data0_rd), .data1_rd(data1_rd),
        .l2_req(l2_req), .l2_addr(l2_addr), .l2_ack(l2_ack),
        .l2_rdata(l2_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // Tag/data RAM: combinational read, write on strobe, complete next cycle
    logic [20:0]  ram_tag [2][256];
    logic [127:0] ram_dat [2][256];
    logic         r_cmp = 1'b0;
    logic         lru [256];

    assign tag0_rd  = ram_tag[0][index];
    assign tag1_rd  = ram_tag[1][index];
    assign data0_rd = ram_dat[0][index];
    assign data1_rd = ram_dat[1][index];
    assign LUR      = lru[index];
    assign complete = r_cmp;

    always @(posedge clk) begin
        r_cmp <= !tag0_rw || !tag1_rw;
        if (!tag0_rw)  ram_tag[0][index] <= {1'b1, tag_wd};
        if (!data0_rw) ram_dat[0][index] <= data_wd;
        if (!tag1_rw)  ram_tag[1][index] <= {1'b1, tag_wd};
        if (!data1_rw) ram_dat[1][index] <= data_wd;
    end

    // Reference model
    logic         mv [2][256];
    logic [19:0]  mt [2][256];
    logic [127:0] l2mem [int unsigned];
    int           eh, em;
    int           nvec, nfail;

    function automatic logic [127:0] get_line(input logic [27:0] la);
        logic [127:0] l;
        if (l2mem.exists(int'(la))) return l2mem[int'(la)];
        for (int w = 0; w < 4; w++)
            l[w*32 +: 32] = {la, 2'(w), 2'b00} ^ 32'hC0DE_0000;
        return l;
    endfunction

    task automatic chk(input string t, input logic [127:0] o,
                       input logic [127:0] e);
        nvec++;
        assert (o === e) else begin
            nfail++;
            $error("FAIL %s: got %h want %h", t, o, e);
        end
    endtask

    function automatic int sat(input int v);
        return (v < 15) ? v + 1 : 15;
    endfunction

    // fl: 0 none, 1 flush in LOOKUP, 2 flush during the miss
    task automatic fetch(input logic [31:0] a, input int fl);
        logic [7:0]   ix;
        logic [19:0]  tg;
        logic [1:0]   wd;
        logic [127:0] ln;
        int           hw, vic, lat;
        ix = a[11:4];
        tg = a[31:12];
        wd = a[3:2];
        ln = get_line(a[31:4]);
        hw = -1;
        if (mv[0][ix] && mt[0][ix] == tg) hw = 0;
        else if (mv[1][ix] && mt[1][ix] == tg) hw = 1;
        vic = !mv[0][ix] ? 0 : !mv[1][ix] ? 1 : int'(lru[ix]);
        @(negedge clk);
        chk("busy_idle", if_busy, 0);
        if_req = 1'b1;
        if_addr = a;
        #1 chk("idx_idle", index, ix);
        @(negedge clk);
        chk("busy_lkp", if_busy, 1);
        if (fl == 1) begin
            if_flush = 1'b1;
            if_req = 1'b0;
            @(negedge clk);
            if_flush = 1'b0;
            chk("lflush_busy", if_busy, 0);
            chk("lflush_valid", if_valid, 0);
            chk("lflush_l2", l2_req, 0);
            chk("lflush_hit", hit_cnt, eh);
            chk("lflush_miss", miss_cnt, em);
            return;
        end
        if (hw >= 0) begin
            @(negedge clk);
            eh = sat(eh);
            chk("hit_valid", if_valid, 1);
            chk("hit_insn", if_insn, ln[{wd, 5'b0} +: 32]);
            chk("hit_l2", l2_req, 0);
            chk("hit_cnt", hit_cnt, eh);
            if_req = 1'b0;
            lru[ix] = (hw == 0);
            return;
        end
        @(negedge clk);
        em = sat(em);
        chk("miss_l2req", l2_req, 1);
        chk("miss_l2addr", l2_addr, {a[31:4], 4'b0});
        chk("miss_cnt", miss_cnt, em);
        if (fl == 2) begin
            if_flush = 1'b1;
            if_req = 1'b0;
        end
        lat = $urandom_range(1, 4);
        repeat (lat) begin
            @(negedge clk);
            if_flush = 1'b0;
            chk("hold_l2req", l2_req, 1);
            chk("hold_l2addr", l2_addr, {a[31:4], 4'b0});
        end
        l2_ack = 1'b1;
        l2_rdata = ln;
        @(negedge clk);
        l2_ack = 1'b0;
        l2_rdata = {4{$urandom}};
        chk("refill_rw", {tag0_rw, data0_rw, tag1_rw, data1_rw},
            (vic == 1) ? 4'b1100 : 4'b0011);
        chk("refill_tag", tag_wd, tg);
        chk("refill_data", data_wd, ln);
        chk("refill_idx", index, ix);
        chk("refill_l2", l2_req, 0);
        @(negedge clk);
        chk("cmp_rw", {tag0_rw, data0_rw, tag1_rw, data1_rw}, 4'b1111);
        chk("cmp_busy", if_busy, 1);
        mv[vic][ix] = 1'b1;
        mt[vic][ix] = tg;
        lru[ix] = (vic == 0);
        if (fl == 2) begin
            @(negedge clk);
            chk("mflush_busy", if_busy, 0);
            chk("mflush_valid", if_valid, 0);
            @(negedge clk);
            chk("mflush_valid2", if_valid, 0);
            return;
        end
        @(negedge clk);
        chk("relkp_valid", if_valid, 0);
        @(negedge clk);
        eh = sat(eh);
        chk("re_valid", if_valid, 1);
        chk("re_insn", if_insn, ln[{wd, 5'b0} +: 32]);
        chk("re_hit", hit_cnt, eh);
        chk("re_miss", miss_cnt, em);
        if_req = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [7:0]  ixs [3];
        int          fl;
        ixs[0] = 8'h23;
        ixs[1] = 8'h10;
        ixs[2] = 8'h7F;
        nvec = 0;
        nfail = 0;
        eh = 0;
        em = 0;
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 256; i++) begin
                ram_tag[w][i] = '0;
                ram_dat[w][i] = '0;
                mv[w][i] = 1'b0;
                mt[w][i] = '0;
            end
        for (int i = 0; i < 256; i++) lru[i] = 1'b0;
        l2mem[32'h123] = {32'h4444_4444, 32'h3333_3333,
                          32'hDEAD_BEEF, 32'h1111_1111};
        reset = 1'b0;
        if_req = 1'b0;
        if_addr = '0;
        if_flush = 1'b0;
        l2_ack = 1'b0;
        l2_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", if_valid, 0);
        chk("rst_insn", if_insn, 0);
        chk("rst_l2req", l2_req, 0);
        chk("rst_l2addr", l2_addr, 0);
        chk("rst_rw", {tag0_rw, data0_rw, tag1_rw, data1_rw}, 4'b1111);
        chk("rst_hit", hit_cnt, 0);
        chk("rst_miss", miss_cnt, 0);
        chk("rst_busy", if_busy, 0);
        reset = 1'b1;

        fetch(32'h0000_1234, 0);
        chk("cold_way0", ram_tag[0][8'h23], {1'b1, 20'h1});
        chk("cold_insn", if_insn, 32'hDEAD_BEEF);
        fetch(32'h0000_1238, 0);
        chk("hit_w2", if_insn, 32'h3333_3333);
        fetch(32'h0000_2230, 0);
        chk("way1_fill", ram_tag[1][8'h23], {1'b1, 20'h2});
        lru[8'h23] = 1'b1;
        fetch(32'h0000_3230, 0);
        chk("lur1_way1", ram_tag[1][8'h23], {1'b1, 20'h3});
        lru[8'h23] = 1'b0;
        fetch(32'h0000_5230, 0);
        chk("lur0_way0", ram_tag[0][8'h23], {1'b1, 20'h5});

        fetch(32'h0000_6100, 2);
        chk("flush_fill", ram_tag[0][8'h10], {1'b1, 20'h6});
        fetch(32'h0000_6200, 1);
        fetch(32'h0000_6200, 0);

        for (int n = 0; n < 40; n++) begin
            a = {20'($urandom_range(1, 4)), ixs[$urandom_range(0, 2)],
                 2'($urandom), 2'b00};
            fl = $urandom_range(0, 9);
            fetch(a, (fl == 0) ? 1 : (fl == 1) ? 2 : 0);
        end

        @(negedge clk);
        if_req = 1'b1;
        if_addr = 32'h0009_9990;
        repeat (2) @(negedge clk);
        chk("mid_l2req", l2_req, 1);
        reset = 1'b0;
        if_req = 1'b0;
        #1;
        chk("mid_rst_l2", l2_req, 0);
        chk("mid_rst_rw", {tag0_rw, data0_rw, tag1_rw, data1_rw}, 4'b1111);
        chk("mid_rst_hit", hit_cnt, 0);
        chk("mid_rst_miss", miss_cnt, 0);
        chk("mid_rst_busy", if_busy, 0);
        @(negedge clk);
        reset = 1'b1;
        eh = 0;
        em = 0;

        fetch(32'h0000_1230, 0);
        repeat (16) fetch(32'h0000_1234, 0);
        chk("sat_hit", hit_cnt, 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
